// File: rtl/and_d6_slice.sv
// Four 6-input LUTs that share one truth-table write port, modelled on an FPGA logic slice.
// Each output bit j looks up its own table using bit j of in0..in5 as the address.
module and_d6_slice #(
    parameter logic [63:0] INIT    = 64'h8000_0000_0000_0000,
    parameter int          OUT_REG = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in0,
    input  logic [3:0]  in1,
    input  logic [3:0]  in2,
    input  logic [3:0]  in3,
    input  logic [3:0]  in4,
    input  logic [3:0]  in5,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_lut,
    input  logic [63:0] cfg_data,
    output logic [3:0]  out
);

    logic [63:0] r_tbl [4];
    logic [5:0]  w_idx [4];
    logic [3:0]  w_result;

    // NOTE: the tables are state that must come up as INIT, so unlike a plain RAM
    // every entry is reset; reset also overrides cfg_we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                r_tbl[j] <= INIT;
            end
        end else if (cfg_we) begin
            for (int j = 0; j < 4; j++) begin
                // NOTE: non-blocking, so a lookup in this cycle still sees the old table.
                if (cfg_lut[j]) begin
                    r_tbl[j] <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        w_result = '0;
        for (int j = 0; j < 4; j++) begin
            w_idx[j]    = {in5[j], in4[j], in3[j], in2[j], in1[j], in0[j]};
            w_result[j] = r_tbl[j][w_idx[j]];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [3:0] r_out;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= 4'b0000;
                end else begin
                    r_out <= w_result;
                end
            end

            assign out = r_out;
        end else begin : g_comb
            assign out = w_result;
        end
    endgenerate

endmodule

// File: tb/tb_and_d6_slice.sv
// Bench for and_d6_slice: several parameterisations share one stimulus bus; combinational
// outputs are checked from a vector table, the registered output through a scoreboard queue.
module tb_and_d6_slice;

    logic        clk;
    logic        rst;
    logic [3:0]  in0, in1, in2, in3, in4, in5;
    logic        cfg_we;
    logic [3:0]  cfg_lut;
    logic [63:0] cfg_data;
    logic [3:0]  o_and6, o_and2, o_and5, o_reg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] v0, v1, v2, v3, v4, v5;
        logic [3:0] exp6, exp2, exp5;
    } vec_t;

    vec_t       vecs [8];
    logic [3:0] sb [$];

    and_d6_slice #(.INIT(64'h8000_0000_0000_0000), .OUT_REG(0)) u_and6 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
        .cfg_we(cfg_we), .cfg_lut(cfg_lut), .cfg_data(cfg_data), .out(o_and6));

    and_d6_slice #(.INIT(64'h8888_8888_8888_8888), .OUT_REG(0)) u_and2 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
        .cfg_we(cfg_we), .cfg_lut(cfg_lut), .cfg_data(cfg_data), .out(o_and2));

    and_d6_slice #(.INIT(64'h8000_0000_8000_0000), .OUT_REG(0)) u_and5 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
        .cfg_we(cfg_we), .cfg_lut(cfg_lut), .cfg_data(cfg_data), .out(o_and5));

    and_d6_slice #(.INIT(64'h8000_0000_0000_0000), .OUT_REG(1)) u_reg (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
        .cfg_we(cfg_we), .cfg_lut(cfg_lut), .cfg_data(cfg_data), .out(o_reg));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a0, a1, a2, a3, a4, a5);
        in0 = a0; in1 = a1; in2 = a2; in3 = a3; in4 = a4; in5 = a5;
    endtask

    task automatic pop_reg(input string name);
        logic [3:0] exp;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %b want an entry", name, o_reg);
        end else begin
            exp = sb.pop_front();
            check(name, o_reg, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r0, r1, r2, r3, r4, r5;

        vecs[0] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[1] = '{4'hF, 4'hF, 4'hF, 4'b1011, 4'hF, 4'hF, 4'b1011, 4'hF, 4'b1011};
        vecs[2] = '{4'h0, 4'hF, 4'hF, 4'b1011, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{4'b1100, 4'b1010, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1000, 4'b1000, 4'b1000};
        vecs[4] = '{4'b1100, 4'b1010, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000, 4'h0};
        vecs[5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
        vecs[6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
        vecs[7] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

        rst = 1'b1; cfg_we = 1'b0; cfg_lut = 4'h0; cfg_data = 64'h0;
        drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        #12;
        check("reset_reg_out", o_reg, 4'h0);
        check("reset_comb_out", o_and6, 4'hF);
        @(negedge clk) rst = 1'b0;

        // Registered output: one cycle of latency, asynchronous clear.
        @(negedge clk) drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk) #1 check("reg_zero", o_reg, 4'h0);
        @(negedge clk) drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        #1 check("reg_not_same_cycle", o_reg, 4'h0);
        check("comb_same_cycle", o_and6, 4'hF);
        @(posedge clk) #1 check("reg_after_edge", o_reg, 4'hF);
        #2 rst = 1'b1;
        #1 check("reg_async_reset", o_reg, 4'h0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3, vecs[i].v4, vecs[i].v5);
            sb.push_back(vecs[i].exp6);
            #1;
            check($sformatf("vec%0d_and6", i), o_and6, vecs[i].exp6);
            check($sformatf("vec%0d_and2", i), o_and2, vecs[i].exp2);
            check($sformatf("vec%0d_and5", i), o_and5, vecs[i].exp5);
            @(posedge clk) #1 pop_reg($sformatf("vec%0d_reg", i));
        end

        // Random patterns, biased toward ones so the wide ANDs actually fire.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            r0 = 4'($urandom) | 4'($urandom); r1 = 4'($urandom) | 4'($urandom);
            r2 = 4'($urandom) | 4'($urandom); r3 = 4'($urandom) | 4'($urandom);
            r4 = 4'($urandom) | 4'($urandom); r5 = 4'($urandom) | 4'($urandom);
            drive(r0, r1, r2, r3, r4, r5);
            sb.push_back(r0 & r1 & r2 & r3 & r4 & r5);
            #1;
            check($sformatf("rnd%0d_and6", i), o_and6, r0 & r1 & r2 & r3 & r4 & r5);
            check($sformatf("rnd%0d_and2", i), o_and2, r0 & r1);
            check($sformatf("rnd%0d_and5", i), o_and5, r0 & r1 & r2 & r3 & r4);
            @(posedge clk) #1 pop_reg($sformatf("rnd%0d_reg", i));
        end

        // Reload LUT0 only, then let reset restore it.
        @(negedge clk);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        cfg_we = 1'b1; cfg_lut = 4'b0001; cfg_data = 64'h1;
        #1 check("cfg_before_edge", o_and6, 4'b0000);
        @(posedge clk) #1 cfg_we = 1'b0;
        check("cfg_after_edge_and6", o_and6, 4'b0001);
        check("cfg_after_edge_and2", o_and2, 4'b0001);
        @(negedge clk) drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        #1 check("cfg_unselected_hold", o_and6, 4'b1110);
        drive(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        #1 rst = 1'b1;
        #1 check("cfg_reset_restores", o_and6, 4'b0000);
        drive(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        #1 check("cfg_reset_init_all_f", o_and6, 4'hF);
        @(negedge clk) rst = 1'b0;

        // Write enable with an empty mask changes nothing.
        @(negedge clk) cfg_we = 1'b1; cfg_lut = 4'h0; cfg_data = 64'h0;
        @(posedge clk) #1 cfg_we = 1'b0;
        check("cfg_empty_mask", o_and6, 4'hF);

        // Write and lookup in the same cycle: old table until the edge.
        @(negedge clk) cfg_we = 1'b1; cfg_lut = 4'hF; cfg_data = 64'h0;
        #1 check("wr_same_cycle_comb", o_and6, 4'hF);
        check("wr_same_cycle_reg", o_reg, 4'hF);
        @(posedge clk) #1 cfg_we = 1'b0;
        check("wr_edge_reg_old", o_reg, 4'hF);
        check("wr_edge_comb_new", o_and6, 4'h0);
        @(posedge clk) #1 check("wr_next_reg_new", o_reg, 4'h0);

        // Write enable held during reset must not load.
        @(negedge clk) rst = 1'b1; cfg_we = 1'b1; cfg_lut = 4'hF; cfg_data = 64'h0;
        repeat (2) @(posedge clk);
        #1 check("we_in_reset_comb", o_and6, 4'hF);
        check("we_in_reset_reg", o_reg, 4'h0);
        @(negedge clk) cfg_we = 1'b0; rst = 1'b0;
        @(posedge clk) #1 check("we_in_reset_after_comb", o_and6, 4'hF);
        check("we_in_reset_after_reg", o_reg, 4'hF);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
